// File: rtl/package_settings.sv
// Purpose: global data-path widths shared across the detector chain.
// Latency: n/a (constants only).
// Backpressure: n/a.
package package_settings;

  // ADC sample width used by the source, the shaping filter and their benches.
  localparam int SIZE_ADC_DATA = 12;

endpackage

// File: rtl/v6_source_params.sv
// Purpose: FSM state type and default shaping constants of the v6 pulse source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package v6_source_params;

  typedef enum logic [1:0] {
    IDLE,
    RISE,
    DECAY
  } state_t;

  // Default pulse shape; the v6 filter benches reuse these so both sides agree.
  localparam int DEF_RISE_SHIFT  = 3;    // rise lasts 2^3 = 8 cycles
  localparam int DEF_DECAY_SHIFT = 4;    // decay loses 1/16 of the pulse per cycle
  localparam int DEF_FRAC        = 8;    // fractional bits in the accumulator
  localparam int DEF_BASELINE    = 100;  // output pedestal in ADC LSB
  localparam int DEF_CNT_W       = 16;   // accepted-trigger counter width

endpackage

// File: rtl/v6_pulse_sat_add.sv
// Purpose: combinational unsigned adder that clamps to the all-ones value of W_OUT bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   i_a, i_b : W_IN-bit unsigned operands
//   o_y      : min(i_a + i_b, 2^W_OUT - 1)
//
// W_OUT == W_IN gives a plain saturating accumulator; W_OUT < W_IN narrows and
// clamps in one step (used to fold baseline + level into the ADC range).
module v6_pulse_sat_add #(
  parameter int W_IN  = 21,
  parameter int W_OUT = 21
) (
  input  logic [W_IN-1:0]  i_a,
  input  logic [W_IN-1:0]  i_b,
  output logic [W_OUT-1:0] o_y
);

  // One extra bit keeps the carry so overflow is never lost before the clamp.
  logic [W_IN:0] w_sum;
  logic          w_over;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Any set bit at or above W_OUT means the result does not fit the output.
  assign w_over = |w_sum[W_IN:W_OUT];
  assign o_y    = w_over ? {W_OUT{1'b1}} : w_sum[W_OUT-1:0];

  generate
    if (W_OUT > W_IN || W_OUT < 1) begin : g_bad_width
      $error("v6_pulse_sat_add: W_OUT must be in 1..W_IN");
    end
  endgenerate

endmodule

// File: rtl/v6_pulse_source.sv
// Purpose: synthetic ADC source emitting baseline + linear-rise / exponential-decay pulses.
// Latency: adc_data is registered, 1 cycle behind the internal pulse accumulator.
// Backpressure: none; free-running each cycle, triggers during RISE are dropped and flagged.
//
// Ports:
//   clk         : sample clock
//   reset       : asynchronous, active-high reset
//   trigger     : one-cycle start strobe, sampled every edge
//   amplitude   : pulse height in LSB, latched on an accepted trigger
//   adc_data    : registered synthesized sample, min(BASELINE + level, full scale)
//   busy        : high whenever the FSM is not IDLE
//   trig_lost   : one-cycle strobe, a trigger arrived during RISE and was ignored
//   pulse_count : number of accepted triggers, wraps modulo 2^CNT_W
module v6_pulse_source
  import package_settings::*;
  import v6_source_params::*;
#(
  parameter int RISE_SHIFT  = DEF_RISE_SHIFT,
  parameter int DECAY_SHIFT = DEF_DECAY_SHIFT,
  parameter int FRAC        = DEF_FRAC,
  parameter int BASELINE    = DEF_BASELINE,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     trigger,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     busy,
  output logic                     trig_lost,
  output logic [CNT_W-1:0]         pulse_count
);

  // Accumulator carries one headroom bit above the ADC range so a pile-up can
  // exceed full scale before the output clamp.
  localparam int PW  = SIZE_ADC_DATA + FRAC + 1;
  localparam int LW  = PW - FRAC;
  // Keep the rise counter at least one bit wide even for a 1-cycle rise.
  localparam int RCW = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;

  localparam logic [RCW-1:0] RISE_LAST = RCW'((1 << RISE_SHIFT) - 1);
  localparam logic [LW-1:0]  BASE_L    = LW'(BASELINE);

  generate
    if (FRAC < RISE_SHIFT) begin : g_bad_frac
      $error("v6_pulse_source: FRAC must be >= RISE_SHIFT so the rise step is exact");
    end
  endgenerate

  state_t                   r_state;
  logic [PW-1:0]            r_pulse;
  logic [PW-1:0]            r_step;
  logic [RCW-1:0]           r_rise_cnt;
  logic [SIZE_ADC_DATA-1:0] r_adc_data;
  logic                     r_trig_lost;
  logic [CNT_W-1:0]         r_pulse_count;

  logic [PW-1:0]            w_amp_ext;
  logic [PW-1:0]            w_step;
  logic [PW-1:0]            w_pulse_sum;
  logic [PW-1:0]            w_pulse_decay;
  logic [LW-1:0]            w_level;
  logic                     w_level_zero;
  logic [SIZE_ADC_DATA-1:0] w_adc_next;

  assign w_amp_ext     = PW'(amplitude);
  // amplitude * 2^FRAC / 2^RISE_SHIFT: with FRAC >= RISE_SHIFT no bits fall off,
  // so 2^RISE_SHIFT steps land exactly on the requested height.
  assign w_step        = (w_amp_ext << FRAC) >> RISE_SHIFT;
  assign w_level       = r_pulse[PW-1:FRAC];
  assign w_level_zero  = (w_level == '0);
  // Subtracting a right-shifted copy of itself can never underflow.
  assign w_pulse_decay = r_pulse - (r_pulse >> DECAY_SHIFT);

  v6_pulse_sat_add #(
    .W_IN  (PW),
    .W_OUT (PW)
  ) u_acc_add (
    .i_a (r_pulse),
    .i_b (r_step),
    .o_y (w_pulse_sum)
  );

  v6_pulse_sat_add #(
    .W_IN  (LW),
    .W_OUT (SIZE_ADC_DATA)
  ) u_out_add (
    .i_a (BASE_L),
    .i_b (w_level),
    .o_y (w_adc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pulse       <= '0;
      r_step        <= '0;
      r_rise_cnt    <= '0;
      r_adc_data    <= SIZE_ADC_DATA'(BASELINE);
      r_trig_lost   <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_trig_lost <= 1'b0;
      // Output tracks the accumulator value from before this edge.
      r_adc_data  <= w_adc_next;

      case (r_state)
        IDLE: begin
          r_pulse <= '0;
          if (trigger) begin
            // Accumulator stays at zero on the accepting edge; the first
            // increment happens on the next edge.
            r_step        <= w_step;
            r_rise_cnt    <= '0;
            r_pulse_count <= r_pulse_count + CNT_W'(1);
            r_state       <= RISE;
          end
        end

        RISE: begin
          r_pulse    <= w_pulse_sum;
          r_rise_cnt <= r_rise_cnt + RCW'(1);
          if (r_rise_cnt == RISE_LAST) begin
            r_state <= DECAY;
          end
          if (trigger) begin
            r_trig_lost <= 1'b1;
          end
        end

        DECAY: begin
          if (trigger) begin
            // Pile-up: hold the current level and start a fresh rise on top.
            // Checked first so it wins over the level-zero exit.
            r_step        <= w_step;
            r_rise_cnt    <= '0;
            r_pulse_count <= r_pulse_count + CNT_W'(1);
            r_state       <= RISE;
          end else if (w_level_zero) begin
            r_pulse <= '0;
            r_state <= IDLE;
          end else begin
            r_pulse <= w_pulse_decay;
          end
        end

        default: begin
          r_pulse <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign adc_data    = r_adc_data;
  assign busy        = (r_state != IDLE);
  assign trig_lost   = r_trig_lost;
  assign pulse_count = r_pulse_count;

endmodule

// File: tb/tb_v6_pulse_source.sv
// Purpose: directed self-checking bench for v6_pulse_source with default parameters.
// Latency: checks adc_data one cycle behind the modelled accumulator.
// Backpressure: n/a; stimulus drives trigger/amplitude directly.
module tb_v6_pulse_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [11:0] amplitude = '0;
  logic [11:0] adc_data;
  logic        busy;
  logic        trig_lost;
  logic [15:0] pulse_count;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  v6_pulse_source dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .amplitude   (amplitude),
    .adc_data    (adc_data),
    .busy        (busy),
    .trig_lost   (trig_lost),
    .pulse_count (pulse_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_adc(input int x);
    return (x > 4095) ? 4095 : x;
  endfunction

  // Advance one clock and settle away from the edge.
  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Accepting trigger from IDLE; the accumulator is still zero so adc shows the baseline.
  task automatic fire(input string tag, input int amp);
    trigger   = 1'b1;
    amplitude = 12'(amp);
    step_edge();
    trigger = 1'b0;
    exp_cnt++;
    chk({tag, "_adc"}, 32'(adc_data), 100);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_cnt"}, 32'(pulse_count), 32'(exp_cnt));
  endtask

  // Eight rise edges; optionally re-trigger on rise edge retrig_k (expected to be lost).
  task automatic rise_phase(input string tag, input int amp, input int p_in,
                            input int retrig_k, output int p_out);
    int p;
    int stp;
    p   = p_in;
    stp = (amp << 8) >> 3;
    for (int k = 1; k <= 8; k++) begin
      int e_adc;
      e_adc = clamp_adc(100 + (p >> 8));
      if (k == retrig_k) begin
        trigger = 1'b1;
      end
      step_edge();
      trigger = 1'b0;
      p = (p + stp > 2097151) ? 2097151 : p + stp;
      chk({tag, "_adc"}, 32'(adc_data), 32'(e_adc));
      chk({tag, "_busy"}, 32'(busy), 1);
      chk({tag, "_lost"}, 32'(trig_lost), (k == retrig_k) ? 32'd1 : 32'd0);
    end
    chk({tag, "_cnt"}, 32'(pulse_count), 32'(exp_cnt));
    p_out = p;
  endtask

  // Decay until the level reaches zero and busy drops, then one idle edge.
  task automatic decay_phase(input string tag, input int p_in);
    int  p;
    bit  done;
    p    = p_in;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      int e_adc;
      int e_busy;
      e_adc = clamp_adc(100 + (p >> 8));
      if ((p >> 8) == 0) begin
        p      = 0;
        e_busy = 0;
        done   = 1'b1;
      end else begin
        p      = p - (p >> 4);
        e_busy = 1;
      end
      step_edge();
      chk({tag, "_adc"}, 32'(adc_data), 32'(e_adc));
      chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
    end
    chk({tag, "_end_busy"}, 32'(busy), 0);
    step_edge();
    chk({tag, "_idle_adc"}, 32'(adc_data), 100);
    chk({tag, "_cnt"}, 32'(pulse_count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;

    // Reset state while reset is held.
    step_edge();
    step_edge();
    chk("rst_adc", 32'(adc_data), 100);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lost", 32'(trig_lost), 0);
    chk("rst_cnt", 32'(pulse_count), 0);
    reset = 1'b0;

    // 1: quiet after release.
    for (int i = 0; i < 20; i++) begin
      step_edge();
      chk("t1_adc", 32'(adc_data), 100);
      chk("t1_busy", 32'(busy), 0);
    end
    chk("t1_cnt", 32'(pulse_count), 0);

    // 2: single pulse, amplitude 800.
    fire("t2_trig", 800);
    rise_phase("t2_rise", 800, 0, 0, p);
    step_edge(); chk("t2_peak", 32'(adc_data), 900); p = p - (p >> 4);
    step_edge(); chk("t2_d1", 32'(adc_data), 850);   p = p - (p >> 4);
    step_edge(); chk("t2_d2", 32'(adc_data), 803);   p = p - (p >> 4);
    decay_phase("t2_decay", p);

    // 3: trigger during RISE is dropped, waveform unchanged.
    fire("t3_trig", 800);
    rise_phase("t3_rise", 800, 0, 4, p);
    step_edge(); chk("t3_peak", 32'(adc_data), 900); p = p - (p >> 4);
    step_edge(); chk("t3_d1", 32'(adc_data), 850);   p = p - (p >> 4);
    decay_phase("t3_decay", p);

    // 4: pile-up with amplitude 400 at L=703.
    fire("t4_trig", 800);
    rise_phase("t4_rise", 800, 0, 0, p);
    step_edge(); chk("t4_peak", 32'(adc_data), 900); p = p - (p >> 4);
    step_edge(); chk("t4_d1", 32'(adc_data), 850);   p = p - (p >> 4);
    trigger   = 1'b1;
    amplitude = 12'd400;
    step_edge();
    trigger = 1'b0;
    exp_cnt++;
    chk("t4_pile_adc", 32'(adc_data), 803);
    chk("t4_pile_busy", 32'(busy), 1);
    chk("t4_pile_cnt", 32'(pulse_count), 32'(exp_cnt));
    rise_phase("t4_rise2", 400, p, 0, p);
    step_edge(); chk("t4_peak2", 32'(adc_data), 1203); p = p - (p >> 4);
    decay_phase("t4_decay", p);

    // 5: full-scale amplitude clamps at 4095 without wrapping.
    fire("t5_trig", 4095);
    rise_phase("t5_rise", 4095, 0, 0, p);
    step_edge(); chk("t5_peak", 32'(adc_data), 4095); p = p - (p >> 4);
    step_edge(); chk("t5_d1", 32'(adc_data), 3939);   p = p - (p >> 4);
    decay_phase("t5_decay", p);

    // Zero amplitude still runs a full rise and exits on the first decay edge.
    fire("z_trig", 0);
    rise_phase("z_rise", 0, 0, 0, p);
    decay_phase("z_decay", p);

    // 6: reset mid-rise.
    fire("t6_trig", 800);
    for (int i = 0; i < 5; i++) begin
      step_edge();
    end
    chk("t6_pre_busy", 32'(busy), 1);
    reset = 1'b1;
    #2;
    chk("t6_rst_adc", 32'(adc_data), 100);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_cnt", 32'(pulse_count), 0);
    step_edge();
    reset   = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step_edge();
      chk("t6_post_adc", 32'(adc_data), 100);
      chk("t6_post_busy", 32'(busy), 0);
    end
    chk("t6_post_cnt", 32'(pulse_count), 0);
    fire("t6_new", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/v6_pulse_source.md
Name: v6_pulse_source

Overview:
- Synthetic detector/ADC sample source; the transmit-side counterpart of the v6 shaping filter.
- On each trigger it emits one ADC-format exponential pulse: a linear rise over 2^RISE_SHIFT cycles, then a decay of value/2^DECAY_SHIFT per cycle, on top of a fixed baseline.
- Drives the v6 filter input in simulation and in on-chip self-test.
- Supports pile-up: a trigger arriving during decay restarts the rise from the current level.

Parameters:
- RISE_SHIFT, 3: rise length = 2^RISE_SHIFT cycles.
- DECAY_SHIFT, 4: decay per cycle = pulse >> DECAY_SHIFT.
- FRAC, 8: fractional bits of the internal accumulator; FRAC >= RISE_SHIFT is required (elaboration error otherwise).
- BASELINE, 100: constant output offset, in ADC LSB.
- CNT_W, 16: width of pulse_count.

Ports:
- clk  in  1  sample clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  1  start pulse; one-cycle strobe, sampled each edge
- amplitude  in  SIZE_ADC_DATA  pulse height in LSB; sampled on the accepting trigger edge
- adc_data  out  SIZE_ADC_DATA  synthesized sample, registered, updated every cycle
- busy  out  1  high while state != IDLE
- trig_lost  out  1  one-cycle strobe; a trigger arrived during RISE and was dropped
- pulse_count  out  CNT_W  accepted triggers, wraps modulo 2^CNT_W

Behaviour:
- Reset values (asynchronous): state=IDLE, pulse=0, step=0, rise_cnt=0, adc_data=BASELINE, busy=0, trig_lost=0, pulse_count=0.
- Internal accumulator pulse is unsigned, SIZE_ADC_DATA+FRAC+1 bits. Level L = pulse >> FRAC.
- Output rule: adc_data <= min(BASELINE + L, 2^SIZE_ADC_DATA-1), registered from the pulse value of the previous cycle. Output latency is 1 cycle after pulse.
- IDLE:
  - pulse held at 0.
  - On trigger: step <= (amplitude << FRAC) >> RISE_SHIFT (exact, since FRAC >= RISE_SHIFT), rise_cnt <= 0, pulse_count++, state <= RISE. pulse does not change on this edge.
- RISE:
  - Each edge: pulse <= sat(pulse + step), rise_cnt++.
  - On the edge where rise_cnt == 2^RISE_SHIFT-1: state <= DECAY.
  - Exactly 2^RISE_SHIFT increments per rise.
  - A trigger during RISE is ignored; trig_lost=1 for one cycle.
- DECAY:
  - Each edge: pulse <= pulse - (pulse >> DECAY_SHIFT).
  - When L == 0 (evaluated on the current pulse): state <= IDLE and pulse <= 0 on that edge.
  - A trigger during DECAY is a pile-up: step is relatched from the new amplitude, rise_cnt <= 0, pulse_count++, state <= RISE. pulse keeps its current value, so the new rise adds to it.
  - A pile-up trigger has priority over the L==0 exit on the same edge.
- Saturation: pulse clamps at all-ones and never wraps. adc_data clamps at full scale.
- amplitude = 0: a full cycle still runs (8 RISE cycles, then DECAY exits immediately); busy toggles; pulse_count increments.
- busy is combinational from state.
- Reset asserted mid-pulse: immediate return to reset values. No pulse resumes after release.

Decomposition:
- package_settings supplies SIZE_ADC_DATA.
- New package v6_source_params holds:
  - typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t
  - default RISE_SHIFT/DECAY_SHIFT/FRAC/BASELINE constants, shared with v6 filter benches.
- One sub-module: v6_pulse_sat_add. Combinational saturating adder/clamp, used for the pulse accumulate and for baseline+level.

Test Plan (SIZE_ADC_DATA=12, defaults):
1. Reset release, no trigger, 20 cycles -> adc_data=100 constant, busy=0, pulse_count=0.
2. Trigger with amplitude=800 at edge T:
   - adc_data = 200, 300, ..., 900 at edges T+2..T+9.
   - Then decay: 850, 803 (L=703), 759, ... monotonic down to 100.
   - busy falls the edge after L hits 0; pulse_count=1.
3. Trigger again (amplitude=800) at edge T+4 of test 2 (during RISE) -> trig_lost=1 for one cycle, waveform identical to test 2, pulse_count=1.
4. Pile-up: second trigger with amplitude=400 three cycles into DECAY (L=703) -> rise resumes, +50 LSB/cycle for 8 cycles, peak L=1103 (adc 1203); pulse_count=2.
5. Saturation: BASELINE=100, amplitude=4095 -> adc_data clamps at 4095 at the peak, no wrap; then decays normally.
6. Reset asserted at cycle 5 of RISE for 1 cycle -> adc_data=100, busy=0, pulse_count=0 immediately; no further pulse until a new trigger.
